// File: rtl/nrom_prg_mapper.sv
// NROM-class program memory block for the CPU address space.
// It holds a 16/32 KiB PRG-ROM that a streaming loader fills,
// plus an optional 2 KiB PRG-RAM mirrored across $6000-$7FFF.
// Read data is registered. The output latch keeps its value on open-bus accesses.
module nrom_prg_mapper #(
  parameter int PRG_BANKS   = 1,
  parameter int HAS_PRG_RAM = 1,
  parameter int PRG_RAM_AW  = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        reload,
  output logic        prg_ready,
  output logic        load_err
);

  localparam int ROM_SIZE = 16384 * PRG_BANKS;
  localparam int ROM_AW   = (PRG_BANKS == 2) ? 15 : 14;
  localparam int RAM_SIZE = 1 << PRG_RAM_AW;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e             state_q;
  logic [ROM_AW-1:0]  cnt_q;
  logic               prg_ready_q;
  logic               load_err_q;
  logic [7:0]         rdata_q;
  logic               rvalid_q;

  logic [7:0] rom_mem [ROM_SIZE];
  logic [7:0] ram_mem [RAM_SIZE];

  logic [ROM_AW-1:0]     rom_idx_s;
  logic [PRG_RAM_AW-1:0] ram_idx_s;
  logic                  is_rom_s;
  logic                  is_ram_s;
  logic                  run_s;
  logic                  ld_fire_s;
  logic                  last_byte_s;
  logic                  rd_s;
  logic                  wr_s;

  // Address decode and handshake qualifiers
  always_comb begin
    rom_idx_s   = cpu_addr[ROM_AW-1:0];
    ram_idx_s   = cpu_addr[PRG_RAM_AW-1:0];
    is_rom_s    = cpu_addr[15];
    is_ram_s    = (cpu_addr[15:13] == 3'b011) && (HAS_PRG_RAM != 0);
    run_s       = (state_q == ST_RUN);
    ld_fire_s   = ld_valid && (state_q == ST_LOAD);
    last_byte_s = (cnt_q == ROM_AW'(ROM_SIZE - 1));
    rd_s        = cpu_cs && cpu_rw;
    wr_s        = cpu_cs && !cpu_rw;
  end

  // The loader is accepted only while loading, so ready simply mirrors the state
  assign ld_ready = (state_q == ST_LOAD);

  // Loader, counter and status FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      prg_ready_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          prg_ready_q <= 1'b0;
          if (ld_valid) begin
            cnt_q <= cnt_q + ROM_AW'(1);
            // The final byte completes the image even when ld_last is also set
            if (last_byte_s) begin
              state_q     <= ST_RUN;
              prg_ready_q <= 1'b1;
            end else if (ld_last) begin
              state_q    <= ST_ERR;
              load_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (reload) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            prg_ready_q <= 1'b0;
          end
        end
        ST_ERR: begin
          // Only an asynchronous reset leaves the error state
          prg_ready_q <= 1'b0;
          load_err_q  <= 1'b1;
        end
        default: begin
          state_q     <= ST_LOAD;
          cnt_q       <= '0;
          prg_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // ROM fill from the loader stream. Contents survive reset and reload
  always_ff @(posedge clk) begin
    if (ld_fire_s) begin
      rom_mem[cnt_q] <= ld_data;
    end
  end

  // PRG-RAM writes. They are only accepted in RUN, and the region mirrors every 2^PRG_RAM_AW bytes
  always_ff @(posedge clk) begin
    if (run_s && wr_s && is_ram_s) begin
      ram_mem[ram_idx_s] <= cpu_wdata;
    end
  end

  // Registered read data with open-bus hold; rvalid pulses for every read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_s;
      if (rd_s && run_s) begin
        if (is_rom_s) begin
          rdata_q <= rom_mem[rom_idx_s];
        end else if (is_ram_s) begin
          rdata_q <= ram_mem[ram_idx_s];
        end
      end
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign prg_ready  = prg_ready_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_nrom_prg_mapper.sv
// Bench for nrom_prg_mapper. Two instances share all stimulus:
//   A = NROM-128 with PRG-RAM
//   B = NROM-256 without PRG-RAM
// Expected read data is queued when a read is driven and popped when rvalid returns.
module tb_nrom_prg_mapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_cs;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        reload;

  logic [7:0]  rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic        ld_ready_a, ld_ready_b;
  logic        prg_ready_a, prg_ready_b;
  logic        load_err_a, load_err_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] last_a;
  logic [7:0] last_b;

  always #5 clk = ~clk;

  nrom_prg_mapper #(.PRG_BANKS(1), .HAS_PRG_RAM(1), .PRG_RAM_AW(11)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_a), .cpu_rvalid(rvalid_a),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_a),
    .reload(reload), .prg_ready(prg_ready_a), .load_err(load_err_a)
  );

  nrom_prg_mapper #(.PRG_BANKS(2), .HAS_PRG_RAM(0), .PRG_RAM_AW(11)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_b), .cpu_rvalid(rvalid_b),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_b),
    .reload(reload), .prg_ready(prg_ready_b), .load_err(load_err_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Image byte i: low address byte xor upper address bits, then xor a salt
  function automatic logic [7:0] img(input int i, input logic [7:0] salt);
    logic [14:0] a;
    a = i[14:0];
    return a[7:0] ^ {1'b0, a[14:8]} ^ salt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic [7:0] ea, input logic [7:0] eb,
                          input logic rl, input string tag);
    logic [7:0] e;
    cpu_cs   = 1'b1;
    cpu_rw   = 1'b1;
    cpu_addr = addr;
    reload   = rl;
    qa.push_back(ea);
    qb.push_back(eb);
    tick();
    cpu_cs = 1'b0;
    reload = 1'b0;
    check_val({tag, "_rvalid_a"}, rvalid_a, 1'b1);
    check_val({tag, "_rvalid_b"}, rvalid_b, 1'b1);
    e = qa.pop_front();
    if (rvalid_a) check_val({tag, "_a"}, rdata_a, e);
    e = qb.pop_front();
    if (rvalid_b) check_val({tag, "_b"}, rdata_b, e);
    last_a = ea;
    last_b = eb;
    tick();
    check_val({tag, "_pulse_a"}, rvalid_a, 1'b0);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d);
    cpu_cs    = 1'b1;
    cpu_rw    = 1'b0;
    cpu_addr  = addr;
    cpu_wdata = d;
    tick();
    cpu_cs = 1'b0;
    cpu_rw = 1'b1;
    check_val("wr_no_rvalid", rvalid_a, 1'b0);
  endtask

  // mode 1: check prg_ready timing around byte 16383 of instance A
  // mode 2: check load_err timing around the byte carrying ld_last
  task automatic load(input int n, input logic [7:0] salt, input int last_at, input int mode);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = img(i, salt);
      ld_last  = (i == last_at);
      tick();
      if (mode == 1 && i == 16382) check_val("prg_ready_early", prg_ready_a, 1'b0);
      if (mode == 1 && i == 16383) check_val("prg_ready_rise", prg_ready_a, 1'b1);
      if (mode == 2 && i == last_at - 1) check_val("load_err_early", load_err_a, 1'b0);
      if (mode == 2 && i == last_at) check_val("load_err_rise", load_err_a, 1'b1);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_addr = 16'h0000; cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_wdata = 8'h00;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0; reload = 1'b0;
    last_a = 8'h00; last_b = 8'h00;
    tick(); tick();
    check_val("rst_rdata", rdata_a, 8'h00);
    check_val("rst_rvalid", rvalid_a, 1'b0);
    check_val("rst_prg_ready", prg_ready_a, 1'b0);
    check_val("rst_load_err", load_err_a, 1'b0);
    check_val("rst_ld_ready", ld_ready_a, 1'b1);
    rst_n = 1'b1;
    tick();
    check_val("ld_ready_after_rst", ld_ready_b, 1'b1);

    // Full image for B; A completes after its first 16 KiB and ignores the rest
    load(32768, 8'h00, 32767, 1);
    check_val("prg_ready_b", prg_ready_b, 1'b1);
    check_val("ld_ready_run_a", ld_ready_a, 1'b0);
    check_val("ld_ready_run_b", ld_ready_b, 1'b0);
    check_val("load_err_run", load_err_b, 1'b0);

    cpu_read(16'hC123, 8'h22, img(16'h4123, 8'h00), 1'b0, "rd_C123");
    cpu_read(16'h8123, 8'h22, img(16'h0123, 8'h00), 1'b0, "rd_8123");
    cpu_read(16'h8000, img(0, 8'h00), img(0, 8'h00), 1'b0, "rd_8000");
    cpu_read(16'hC000, img(0, 8'h00), img(16384, 8'h00), 1'b0, "rd_C000");

    // RAM mirroring on A; B has no RAM, so it reads open bus
    cpu_write(16'h6010, 8'hA5);
    cpu_read(16'h6810, 8'hA5, last_b, 1'b0, "ram_6810");
    cpu_read(16'h7010, 8'hA5, last_b, 1'b0, "ram_7010");
    cpu_write(16'h9000, 8'h5A);
    cpu_read(16'h9000, img(16'h1000, 8'h00), img(16'h1000, 8'h00), 1'b0, "rom_wr_ignored");

    // Open bus outside ROM/RAM
    cpu_read(16'h8001, img(1, 8'h00), img(1, 8'h00), 1'b0, "rd_8001");
    cpu_read(16'h4800, last_a, last_b, 1'b0, "open_4800");

    // Reload together with a read: the read is served, then LOAD takes effect
    cpu_read(16'h8002, img(2, 8'h00), img(2, 8'h00), 1'b1, "rd_with_reload");
    check_val("reload_prg_ready", prg_ready_a, 1'b0);
    check_val("reload_ld_ready", ld_ready_a, 1'b1);
    cpu_read(16'h8003, last_a, last_b, 1'b0, "open_in_load");
    cpu_write(16'h6010, 8'h00);

    // Early ld_last on byte 100 sends both instances to ERR
    load(101, 8'h00, 100, 2);
    check_val("err_prg_ready", prg_ready_a, 1'b0);
    check_val("err_load_err_b", load_err_b, 1'b1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tick();
    check_val("err_reload_ignored", load_err_a, 1'b1);
    check_val("err_ld_ready", ld_ready_a, 1'b0);
    rst_n = 1'b0;
    #2;
    check_val("rst_clears_err", load_err_a, 1'b0);
    check_val("rst_clears_rdata", rdata_a, 8'h00);
    tick();
    rst_n = 1'b1;
    last_a = 8'h00;
    last_b = 8'h00;

    // Partial load, reset mid-stream, then a full new image
    load(5000, 8'hC3, -1, 0);
    rst_n = 1'b0;
    #2;
    check_val("midload_rst_ready", ld_ready_a, 1'b1);
    tick();
    rst_n = 1'b1;
    load(32768, 8'h5A, 32767, 1);
    check_val("reload_prg_ready_b", prg_ready_b, 1'b1);
    cpu_read(16'h8005, img(5, 8'h5A), img(5, 8'h5A), 1'b0, "new_8005");
    cpu_read(16'h9387, img(16'h1387, 8'h5A), img(16'h1387, 8'h5A), 1'b0, "new_9387");
    cpu_read(16'hFFFF, img(16'h3FFF, 8'h5A), img(16'h7FFF, 8'h5A), 1'b0, "new_FFFF");
    cpu_read(16'h6010, 8'hA5, last_b, 1'b0, "ram_kept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
